// File: rtl/register_file_unit.sv
// Integer register file fed by writeback: two combinational read ports with same-cycle
// write bypass, one write port, x0 hardwired to zero, x2 reset to SP_INIT, retired-write counter.
module register_file_unit #(
    parameter int                    CORE         = 0,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDRESS_BITS = 5,
    parameter logic [DATA_WIDTH-1:0] SP_INIT      = 32'h0000FFF0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] read_sel1,
    input  logic [ADDRESS_BITS-1:0] read_sel2,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data1,
    output logic [DATA_WIDTH-1:0]   read_data2,
    output logic [31:0]             write_count,
    input  logic                    report
);

    localparam int DEPTH = 2 ** ADDRESS_BITS;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [31:0]           cycle_count;
    logic                  commit;

    // Writes to x0 are dropped entirely so they neither change storage nor count.
    assign commit = write && (write_reg != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == 2) ? SP_INIT : '0;
            end
            write_count <= '0;
            cycle_count <= '0;
        end else begin
            if (commit) begin
                regs[write_reg] <= write_data;
                write_count     <= write_count + 32'd1;
            end
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Bypass is applied before the x0 override so x0 always reads zero.
    always_comb begin
        read_data1 = regs[read_sel1];
        if (write && (write_reg == read_sel1)) read_data1 = write_data;
        if (read_sel1 == '0) read_data1 = '0;
    end

    always_comb begin
        read_data2 = regs[read_sel2];
        if (write && (write_reg == read_sel2)) read_data2 = write_data;
        if (read_sel2 == '0) read_data2 = '0;
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (report) begin
            $display("core %0d cycle %0d rs1 %0d rs2 %0d rd1 %h rd2 %h we %0b wreg %0d wdata %h wcount %0d",
                     CORE, cycle_count, read_sel1, read_sel2, read_data1, read_data2,
                     write, write_reg, write_data, write_count);
        end
    end
`endif

endmodule

// File: tb/tb_register_file_unit.sv
// Self-checking bench for register_file_unit: directed vector table, hand sequences for
// reset/write collisions and full-file fill, then random traffic against an array model.
module tb_register_file_unit;

    localparam logic [31:0] SP = 32'h0000FFF0;

    logic        clock;
    logic        reset;
    logic [4:0]  read_sel1, read_sel2, write_reg;
    logic        write, report;
    logic [31:0] write_data, read_data1, read_data2, write_count;

    register_file_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(5), .SP_INIT(SP)) dut (
        .clock(clock), .reset(reset), .read_sel1(read_sel1), .read_sel2(read_sel2),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_count(write_count), .report(report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_count;
    logic [31:0] got1, got2;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] sel, input logic wr,
                                               input logic [4:0] wreg, input logic [31:0] wdata);
        if (sel == 0) return 32'd0;
        if (wr && wreg == sel) return wdata;
        return model_regs[sel];
    endfunction

    // Called just after a negedge: drive, sample reads mid-cycle, take the posedge, return at next negedge.
    task automatic step(input logic rst, input logic wr, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic [4:0] s1, input logic [4:0] s2);
        reset = rst; write = wr; write_reg = wreg; write_data = wdata;
        read_sel1 = s1; read_sel2 = s2;
        #2;
        got1 = read_data1;
        got2 = read_data2;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_regs[2] = SP;
            model_count = 32'd0;
        end else if (wr && wreg != 0) begin
            model_regs[wreg] = wdata;
            model_count = model_count + 32'd1;
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; write_reg = '0; write_data = '0;
        read_sel1 = '0; read_sel2 = '0; report = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'hxxxxxxxx;
        model_count = 32'hxxxxxxxx;

        vecs[0] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd2, 5'd5, SP,           32'h0,        32'd0};
        vecs[1] = '{1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0,        32'd1};
        vecs[2] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        vecs[3] = '{1'b0, 1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 32'h0,        32'h0,        32'd1};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 32'h0,        32'hDEADBEEF, 32'd1};
        vecs[5] = '{1'b0, 1'b1, 5'd3, 32'd11,       5'd3, 5'd3, 32'd11,       32'd11,       32'd2};
        vecs[6] = '{1'b0, 1'b1, 5'd3, 32'd22,       5'd3, 5'd3, 32'd22,       32'd22,       32'd3};
        vecs[7] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 32'd22,       32'd22,       32'd3};

        @(negedge clock);
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("reset_write_count", write_count, 32'd0);

        for (int v = 0; v < 8; v++) begin
            step(vecs[v].rst, vecs[v].wr, vecs[v].wreg, vecs[v].wdata, vecs[v].s1, vecs[v].s2);
            check($sformatf("vec%0d_rd1", v), got1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), got2, vecs[v].exp2);
            check($sformatf("vec%0d_count", v), write_count, vecs[v].exp_count);
        end

        // A write colliding with reset must be discarded.
        step(1'b1, 1'b1, 5'd9, 32'd55, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd2);
        check("reset_wins_x9", got1, 32'd0);
        check("reset_wins_sp", got2, SP);
        check("reset_wins_count", write_count, 32'd0);

        // Fill every non-zero register with its own index, with a report pulse on the last write.
        for (int i = 1; i < 32; i++) begin
            report = (i == 31);
            step(1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'd0);
            check($sformatf("fill_bypass_x%0d", i), got1, 32'(i));
        end
        report = 1'b0;
        check("fill_count", write_count, 32'd31);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            check($sformatf("fill_rd1_x%0d", i), got1, 32'(i));
            check($sformatf("fill_rd2_x%0d", 31 - i), got2, 32'(31 - i));
        end

        // Random traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            logic        r_rst, r_wr;
            logic [4:0]  r_wreg, r_s1, r_s2;
            logic [31:0] r_wdata, e1, e2;
            r_rst   = ($urandom_range(0, 39) == 0);
            r_wr    = ($urandom_range(0, 2) != 0);
            r_wreg  = 5'($urandom_range(0, 31));
            r_wdata = $urandom;
            r_s1    = ($urandom_range(0, 3) == 0) ? r_wreg : 5'($urandom_range(0, 31));
            r_s2    = ($urandom_range(0, 3) == 0) ? r_s1   : 5'($urandom_range(0, 31));
            e1 = model_read(r_s1, r_wr, r_wreg, r_wdata);
            e2 = model_read(r_s2, r_wr, r_wreg, r_wdata);
            step(r_rst, r_wr, r_wreg, r_wdata, r_s1, r_s2);
            if (!r_rst) begin
                check($sformatf("rand%0d_rd1", n), got1, e1);
                check($sformatf("rand%0d_rd2", n), got2, e2);
            end
            check($sformatf("rand%0d_count", n), write_count, model_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
